key_repeat_gen: RTL and testbench



---
 rtl/key_repeat_pkg.sv | 15 +
 rtl/key_repeat_gen_if.sv | 11 +
 rtl/key_repeat_gen_load_counter.sv | 27 ++
 rtl/key_repeat_gen.sv | 130 +++++++++++++
 tb/tb_key_repeat_gen.sv | 181 ++++++++++++++++++
 5 files changed

// File: rtl/key_repeat_pkg.sv
// Shared types and default timing for the key repeat generators (100 MHz clock).
package key_repeat_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    REPEAT = 2'd2
  } state_t;

  localparam int unsigned DEF_INITIAL_DELAY = 29_999_999;
  localparam int unsigned DEF_REPEAT_PERIOD = 9_999_999;
  localparam int unsigned DEF_ACCEL_AFTER   = 4;
  localparam int unsigned DEF_FAST_PERIOD   = 4_999_999;

endpackage

// File: rtl/key_repeat_gen_if.sv
// Button-side signal bundle between debouncer/game FSM and key_repeat_gen.
interface key_repeat_gen_if;
  logic debounced;
  logic enable;
  logic pulse;
  logic held;
  logic repeating;

  modport master (output debounced, enable, input pulse, held, repeating);
  modport slave  (input debounced, enable, output pulse, held, repeating);
endinterface

// File: rtl/key_repeat_gen_load_counter.sv
// Loadable down-counter that stops at zero; load wins over decrement.
module load_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          load,
  input  logic [CW-1:0] load_val,
  input  logic          dec,
  output logic          zero
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/key_repeat_gen.sv
// Press/auto-repeat pulse generator for one button. Optional repeat acceleration
// is compiled in with `define KEY_REPEAT_ACCEL_EN.
module key_repeat_gen
  import key_repeat_pkg::*;
#(
  parameter int unsigned INITIAL_DELAY = DEF_INITIAL_DELAY,
  parameter int unsigned REPEAT_PERIOD = DEF_REPEAT_PERIOD,
`ifdef KEY_REPEAT_ACCEL_EN
  parameter int unsigned ACCEL_AFTER   = DEF_ACCEL_AFTER,
  parameter int unsigned FAST_PERIOD   = DEF_FAST_PERIOD,
`endif
  parameter int          CW            = $clog2(INITIAL_DELAY + 1)
) (
  input  logic           clk,
  input  logic           reset_n,
  key_repeat_gen_if.slave bus
);

  if (REPEAT_PERIOD > INITIAL_DELAY) begin : g_chk_period_fit
    $error("key_repeat_gen: REPEAT_PERIOD must not exceed INITIAL_DELAY");
  end
  if (REPEAT_PERIOD < 1) begin : g_chk_period_min
    $error("key_repeat_gen: REPEAT_PERIOD must be at least 1");
  end
  if (CW < $clog2(INITIAL_DELAY + 1)) begin : g_chk_cw
    $error("key_repeat_gen: CW too narrow for INITIAL_DELAY");
  end
`ifdef KEY_REPEAT_ACCEL_EN
  if (FAST_PERIOD < 1 || FAST_PERIOD > INITIAL_DELAY) begin : g_chk_fast
    $error("key_repeat_gen: FAST_PERIOD must be in 1..INITIAL_DELAY");
  end
`endif

  state_t        state, state_n;
  logic          pulse_q, pulse_n;
  logic          repeating_q;
  logic          prev;
  logic          armed;
  logic          rise;
  logic          load, dec, zero;
  logic [CW-1:0] load_val;
  logic [CW-1:0] period;

  // armed blocks a level that was already high out of reset until it is released once.
  assign rise = bus.debounced & ~prev & armed;

  always_comb begin
    state_n  = state;
    pulse_n  = 1'b0;
    load     = 1'b0;
    load_val = period;
    dec      = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n  = DELAY;
          pulse_n  = 1'b1;
          load     = 1'b1;
          load_val = CW'(INITIAL_DELAY);
        end
      end
      DELAY, REPEAT: begin
        if (!bus.debounced) begin
          state_n = IDLE;
        end else if (zero) begin
          state_n = REPEAT;
          pulse_n = 1'b1;
          load    = 1'b1;
        end else begin
          dec = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    if (!bus.enable) begin
      state_n = IDLE;
      pulse_n = 1'b0;
      load    = 1'b0;
      dec     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pulse_q     <= 1'b0;
      repeating_q <= 1'b0;
      prev        <= 1'b0;
      armed       <= 1'b0;
    end else begin
      state       <= state_n;
      pulse_q     <= pulse_n;
      repeating_q <= (state_n == REPEAT);
      prev        <= bus.debounced;
      armed       <= armed | ~bus.debounced;
    end
  end

`ifdef KEY_REPEAT_ACCEL_EN
  localparam int AW = (ACCEL_AFTER > 0) ? $clog2(ACCEL_AFTER + 1) : 1;
  logic [AW-1:0] rpt_cnt;

  // Reload choice uses the count of repeats emitted before the current one.
  always_ff @(posedge clk) begin
    if (!reset_n || state_n == IDLE) begin
      rpt_cnt <= '0;
    end else if (pulse_n && state != IDLE && rpt_cnt < AW'(ACCEL_AFTER)) begin
      rpt_cnt <= rpt_cnt + AW'(1);
    end
  end

  assign period = (rpt_cnt >= AW'(ACCEL_AFTER)) ? CW'(FAST_PERIOD) : CW'(REPEAT_PERIOD);
`else
  assign period = CW'(REPEAT_PERIOD);
`endif

  load_counter #(.CW(CW)) u_cnt (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (load),
    .load_val (load_val),
    .dec      (dec),
    .zero     (zero)
  );

  assign bus.pulse     = pulse_q;
  assign bus.held      = prev;
  assign bus.repeating = repeating_q;

endmodule

// File: tb/tb_key_repeat_gen.sv
// Directed + random bench for key_repeat_gen against a countdown-to-next-pulse model.
module tb_key_repeat_gen;

  localparam int unsigned ID = 9;
  localparam int unsigned RP = 3;
`ifdef KEY_REPEAT_ACCEL_EN
  localparam int unsigned AA = 2;
  localparam int unsigned FP = 1;
`endif

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  key_repeat_gen_if bus();

  key_repeat_gen #(
    .INITIAL_DELAY (ID),
`ifdef KEY_REPEAT_ACCEL_EN
    .ACCEL_AFTER   (AA),
    .FAST_PERIOD   (FP),
`endif
    .REPEAT_PERIOD (RP)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int t_now = 0;

  // Reference model: cycles remaining until the next pulse of the current hold.
  bit m_armed, m_prev, m_active;
  int m_wait, m_rep;
  bit e_pulse, e_held, e_rep;
  logic last_pulse = 1'b0;

  task automatic model_edge(input bit d, input bit en, input bit rn);
    int gap;
    if (!rn) begin
      m_armed = 0; m_prev = 0; m_active = 0; m_rep = 0; m_wait = 0;
      e_pulse = 0; e_held = 0; e_rep = 0;
      return;
    end
    e_pulse = 0;
    if (!en) begin
      m_active = 0;
    end else if (m_active) begin
      if (!d) begin
        m_active = 0;
      end else begin
        m_wait = m_wait - 1;
        if (m_wait == 0) begin
`ifdef KEY_REPEAT_ACCEL_EN
          gap = (m_rep >= int'(AA)) ? int'(FP) + 1 : int'(RP) + 1;
`else
          gap = int'(RP) + 1;
`endif
          e_pulse = 1;
          m_rep   = m_rep + 1;
          m_wait  = gap;
        end
      end
    end else if (d && !m_prev && m_armed) begin
      m_active = 1;
      e_pulse  = 1;
      m_rep    = 0;
      m_wait   = int'(ID) + 1;
    end
    e_rep   = m_active && (m_rep > 0);
    m_armed = m_armed | !d;
    m_prev  = d;
    e_held  = d;
  endtask

  task automatic check(input string tag, input logic act, input logic exp);
    n_vec++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s at t=%0d: observed %b expected %b", tag, t_now, act, exp);
    end
  endtask

  task automatic check_int(input string tag, input int act, input int exp);
    n_vec++;
    assert (act === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic step(input bit d, input bit en, input bit rn);
    bus.debounced = d;
    bus.enable    = en;
    reset_n       = rn;
    @(posedge clk);
    model_edge(d, en, rn);
    #1;
    check("pulse", bus.pulse, e_pulse);
    check("held", bus.held, e_held);
    check("repeating", bus.repeating, e_rep);
    check("no_double_pulse", last_pulse & bus.pulse, 1'b0);
    last_pulse = bus.pulse;
    t_now++;
  endtask

  task automatic repeat_step(input int n, input bit d, input bit en, input bit rn);
    for (int i = 0; i < n; i++) step(d, en, rn);
  endtask

  initial begin
    int got_t[$];
    int exp_t[$];
    bit d, en, rn;

    bus.debounced = 1'b0;
    bus.enable    = 1'b1;

    // Level high through reset, then reset released while still held: no pulse.
    repeat_step(3, 1, 1, 0);
    repeat_step(5, 1, 1, 1);
    // Low then high: pulse one cycle later; short tap gives exactly one pulse.
    repeat_step(2, 0, 1, 1);
    repeat_step(5, 1, 1, 1);
    repeat_step(4, 0, 1, 1);

    // Long hold with explicit pulse timeline.
    for (int i = 0; i < 40; i++) begin
      step(1, 1, 1);
      if (bus.pulse) got_t.push_back(i + 1);
    end
    repeat_step(3, 0, 1, 1);
`ifdef KEY_REPEAT_ACCEL_EN
    exp_t = '{1, 11, 15, 19, 21, 23, 25, 27, 29, 31, 33, 35, 37, 39};
`else
    exp_t = '{1, 11, 15, 19, 23, 27, 31, 35, 39};
`endif
    check_int("hold_pulse_count", got_t.size(), exp_t.size());
    for (int i = 0; i < exp_t.size(); i++) begin
      check_int("hold_pulse_time", (i < got_t.size()) ? got_t[i] : -1, exp_t[i]);
    end

    // Release exactly when the delay counter reaches zero, then immediate re-press.
    repeat_step(10, 1, 1, 1);
    repeat_step(1, 0, 1, 1);
    repeat_step(2, 1, 1, 1);
    repeat_step(3, 0, 1, 1);

    // enable dropped during REPEAT, restored while still held, then a fresh press.
    repeat_step(16, 1, 1, 1);
    repeat_step(4, 1, 0, 1);
    repeat_step(12, 1, 1, 1);
    repeat_step(2, 0, 1, 1);
    repeat_step(2, 1, 1, 1);
    repeat_step(2, 0, 1, 1);

    // Reset in the middle of a hold: silent until release and re-press.
    repeat_step(12, 1, 1, 1);
    repeat_step(2, 1, 1, 0);
    repeat_step(6, 1, 1, 1);
    repeat_step(1, 0, 1, 1);
    repeat_step(3, 1, 1, 1);
    repeat_step(2, 0, 1, 1);

    // Random holds/taps with occasional enable drops and resets.
    d = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(14) == 0) d = ~d;
      en = ($urandom_range(39) != 0);
      rn = ($urandom_range(199) != 0);
      step(d, en, rn);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
